// File: rtl/prewitt_window_if.sv
// prewitt_window_if: pixel stream in, 3x3 window out; p[0]..p[8] are p0..p8 row-major
interface prewitt_window_if;
  logic            in_valid;
  logic            in_sof;
  logic [7:0]      in_pixel;
  logic            win_valid;
  logic            win_last;
  logic [8:0][7:0] p;
  modport master (output in_valid, in_sof, in_pixel, input win_valid, win_last, p);
  modport slave (input in_valid, in_sof, in_pixel, output win_valid, win_last, p);
endinterface

// File: rtl/prewitt_window.sv
// prewitt_window: streaming 3x3 neighbourhood generator with two line buffers
module prewitt_window #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic clk,
  input logic rst,
  prewitt_window_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col_q, col_d, col_a;
  logic [RW-1:0] row_q, row_d, row_a;
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb0_rd, lb1_rd;
  // two registered columns per line; the live taps (lb0_rd, lb1_rd, in_pixel) form the rightmost column
  logic [1:0][7:0] top_q, mid_q, bot_q;
  logic [8:0][7:0] p_q, p_d;
  logic wv_q, wv_d, wl_q, wl_d, col_end, row_end;
  always_comb begin
    col_a = s.in_sof ? '0 : col_q;
    row_a = s.in_sof ? '0 : row_q;
    col_end = col_a == CW'(IMG_W - 1);
    row_end = row_a == RW'(IMG_H - 1);
    col_d = col_end ? '0 : col_a + CW'(1);
    row_d = col_end ? (row_end ? '0 : row_a + RW'(1)) : row_a;
    lb0_rd = lb0[col_a];
    lb1_rd = lb1[col_a];
    wv_d = s.in_valid && col_a >= CW'(2) && row_a >= RW'(2);
    wl_d = s.in_valid && col_end && row_end;
    p_d = wv_d ? {s.in_pixel, bot_q, lb1_rd, mid_q, lb0_rd, top_q} : p_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
      p_q <= '0;
      wv_q <= 1'b0;
      wl_q <= 1'b0;
    end else begin
      wv_q <= wv_d;
      wl_q <= wl_d;
      p_q <= p_d;
      if (s.in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        top_q <= {lb0_rd, top_q[1]};
        mid_q <= {lb1_rd, mid_q[1]};
        bot_q <= {s.in_pixel, bot_q[1]};
      end
    end
  always_ff @(posedge clk)
    if (s.in_valid) begin
      lb1[col_a] <= s.in_pixel;
      lb0[col_a] <= lb1_rd;
    end
  assign s.win_valid = wv_q;
  assign s.win_last = wl_q;
  assign s.p = p_q;
endmodule
